// File: rtl/gf233_pkg.sv
// Shared types and constants for the GF(2^233) squaring engine.
// Field: f(x) = x^233 + x^74 + 1.
package gf233_pkg;

    localparam int GF_M     = 233;
    localparam int GF_TRI_K = 74;
    localparam int GF_CNT_W = 8;

    typedef logic [GF_M-1:0]     gf_elem_t;
    typedef logic [GF_CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sqr_state_t;

endpackage

// File: rtl/gf233_sqr_seq_if.sv
// Request/result bundle for the iterated-squaring sequencer.
// master drives start/k/a_in; slave returns busy/done/d_out.
interface gf233_sqr_seq_if;
    import gf233_pkg::*;

    logic     start;
    cnt_t     k;
    gf_elem_t a_in;
    logic     busy;
    logic     done;
    gf_elem_t d_out;

    modport master (output start, output k, output a_in,
                    input  busy,  input  done, input d_out);
    modport slave  (input  start, input  k, input  a_in,
                    output busy,  output done, output d_out);
endinterface

// File: rtl/gf233_sqr_comb.sv
// Combinational squarer: y = a^2 mod (x^233 + x^74 + 1).
// Latency: zero (pure XOR network).
// Backpressure: none, no state.
module gf233_sqr_comb
    import gf233_pkg::*;
(
    input  gf_elem_t a,
    output gf_elem_t y
);

    logic [2*GF_M-2:0] t;

    always_comb begin
        t = '0;
        // Squaring in GF(2) just interleaves zeros between the operand bits.
        for (int i = 0; i < GF_M; i++) begin
            t[2*i] = a[i];
        end
        // Fold from the top down; x^233 = x^74 + 1, so high folds land below i.
        for (int i = 2*GF_M-2; i >= GF_M; i--) begin
            t[i-GF_M]          = t[i-GF_M] ^ t[i];
            t[i-GF_M+GF_TRI_K] = t[i-GF_M+GF_TRI_K] ^ t[i];
        end
        y = t[GF_M-1:0];
    end

endmodule

// File: rtl/gf233_sqr_seq.sv
// Iterated squarer d = a^(2^k) over GF(2^233); build option GF233_SQR_DOUBLE_EN chains two squarers.
// Latency: k+1 edges from accept to done (ceil(k/2)+1 with GF233_SQR_DOUBLE_EN).
// Backpressure: one op in flight; start ignored while busy, no queueing.
module gf233_sqr_seq
    import gf233_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    gf233_sqr_seq_if.slave  bus
);

    sqr_state_t state_q, state_d;
    gf_elem_t   acc_q, acc_d;
    cnt_t       cnt_q, cnt_d;
    gf_elem_t   sqr1;

    gf233_sqr_comb u_sqr1 (.a(acc_q), .y(sqr1));

`ifdef GF233_SQR_DOUBLE_EN
    gf_elem_t sqr2;
    gf233_sqr_comb u_sqr2 (.a(sqr1), .y(sqr2));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.a_in;
                    cnt_d   = bus.k;
                    state_d = (bus.k == '0) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef GF233_SQR_DOUBLE_EN
                if (cnt_q >= cnt_t'(2)) begin
                    acc_d = sqr2;
                    cnt_d = cnt_q - cnt_t'(2);
                end else begin
                    acc_d = sqr1;
                    cnt_d = cnt_q - cnt_t'(1);
                end
                if (cnt_q <= cnt_t'(2)) begin
                    state_d = DONE;
                end
`else
                acc_d = sqr1;
                cnt_d = cnt_q - cnt_t'(1);
                if (cnt_q == cnt_t'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result is a straight view of the accumulator; it only moves on accept or in RUN.
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.d_out = acc_q;

endmodule
